// File: rtl/johnson_phase_tracker.sv
// Johnson counter phase tracker: legality and order checks, phase decode,
// lock FSM, wrap pulse and a saturating error count.
module johnson_phase_tracker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8,
    localparam int N       = 2 * WIDTH,
    localparam int IW      = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] code_in,
    input  logic             code_valid,
    input  logic             clear_err,
    output logic [IW-1:0]    phase_idx,
    output logic [N-1:0]     phase_onehot,
    output logic             locked,
    output logic             wrap_pulse,
    output logic             illegal_code,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [1:0] UNLOCKED = 2'd0;
    localparam logic [1:0] ACQUIRE  = 2'd1;
    localparam logic [1:0] LOCKED   = 2'd2;

    logic [1:0]       r_state;
    logic [GW-1:0]    r_good;
    logic [IW-1:0]    r_idx;
    logic [ERR_W-1:0] r_err;
    logic             r_wrap;
    logic             r_ill;
    logic             r_seq;

    logic             w_legal;
    logic [IW-1:0]    w_idx;
    logic [IW-1:0]    w_next_idx;
    logic             w_succ;
    logic             w_stall;
    logic             w_seq;
    logic             w_err;
    logic [GW-1:0]    w_good_nx;

    // Each legal code is either k ones from the MSB or m ones from the LSB.
    always_comb begin
        w_legal = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (code_in == WIDTH'((1 << k) - 1)) begin
                w_legal = 1'b1;
                w_idx   = (k == 0) ? '0 : IW'(N - k);
            end
            if (code_in == WIDTH'(~((1 << (WIDTH - 1 - k)) - 1))) begin
                w_legal = 1'b1;
                w_idx   = IW'(k + 1);
            end
        end
    end

    assign w_next_idx = (r_idx == IW'(N - 1)) ? '0 : r_idx + IW'(1);
    assign w_succ     = w_legal && (w_idx == w_next_idx);
    assign w_stall    = w_legal && (w_idx == r_idx);
    assign w_seq      = w_legal && (r_state != UNLOCKED) && !w_succ && !w_stall;
    assign w_err      = code_valid && (!w_legal || w_seq);
    assign w_good_nx  = r_good + GW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= UNLOCKED;
            r_good  <= '0;
            r_idx   <= '0;
            r_err   <= '0;
            r_wrap  <= 1'b0;
            r_ill   <= 1'b0;
            r_seq   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_ill  <= 1'b0;
            r_seq  <= 1'b0;
            if (clear_err)
                r_err <= '0;
            else if (w_err && (r_err != {ERR_W{1'b1}}))
                r_err <= r_err + ERR_W'(1);
            if (code_valid) begin
                if (!w_legal) begin
                    r_ill   <= 1'b1;
                    r_state <= UNLOCKED;
                end else begin
                    r_idx <= w_idx;
                    case (r_state)
                        UNLOCKED: begin
                            r_state <= ACQUIRE;
                            r_good  <= '0;
                        end
                        ACQUIRE: begin
                            if (w_succ) begin
                                r_good <= w_good_nx;
                                if (w_good_nx == GW'(LOCK_CNT))
                                    r_state <= LOCKED;
                            end else if (!w_stall) begin
                                r_seq  <= 1'b1;
                                r_good <= '0;
                            end
                        end
                        LOCKED: begin
                            if (w_succ) begin
                                r_wrap <= (r_idx == IW'(N - 1));
                            end else if (!w_stall) begin
                                r_seq   <= 1'b1;
                                r_state <= ACQUIRE;
                                r_good  <= '0;
                            end
                        end
                        default: begin
                            r_state <= UNLOCKED;
                            r_good  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign locked       = (r_state == LOCKED);
    assign phase_idx    = r_idx;
    assign phase_onehot = locked ? (N'(1) << r_idx) : '0;
    assign wrap_pulse   = r_wrap;
    assign illegal_code = r_ill;
    assign seq_err      = r_seq;
    assign err_count    = r_err;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Randomized bench for johnson_phase_tracker against a table-driven
// behavioural model; a second instance with ERR_W=2 covers saturation.
module tb_johnson_phase_tracker;

    localparam int W  = 4;
    localparam int N  = 2 * W;
    localparam int LC = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] code_in = '0;
    logic         code_valid = 1'b0;
    logic         clear_err = 1'b0;

    logic [2:0]   phase_idx, s_phase_idx;
    logic [N-1:0] phase_onehot, s_phase_onehot;
    logic         locked, s_locked;
    logic         wrap_pulse, s_wrap_pulse;
    logic         illegal_code, s_illegal_code;
    logic         seq_err, s_seq_err;
    logic [7:0]   err_count;
    logic [1:0]   s_err_count;

    johnson_phase_tracker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(8)) u_dut (
        .clk(clk), .reset(reset), .code_in(code_in),
        .code_valid(code_valid), .clear_err(clear_err),
        .phase_idx(phase_idx), .phase_onehot(phase_onehot),
        .locked(locked), .wrap_pulse(wrap_pulse),
        .illegal_code(illegal_code), .seq_err(seq_err),
        .err_count(err_count)
    );

    johnson_phase_tracker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(2)) u_sat (
        .clk(clk), .reset(reset), .code_in(code_in),
        .code_valid(code_valid), .clear_err(clear_err),
        .phase_idx(s_phase_idx), .phase_onehot(s_phase_onehot),
        .locked(s_locked), .wrap_pulse(s_wrap_pulse),
        .illegal_code(s_illegal_code), .seq_err(s_seq_err),
        .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int tbl [1 << W];
    int m_mode, m_good, m_idx, m_err8, m_err2;
    int m_wrap, m_ill, m_seq;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int jc(input int i);
        if (i <= W) return ((1 << i) - 1) << (W - i);
        return (1 << (N - i)) - 1;
    endfunction

    task automatic model_step(input int c, input bit v, input bit clr,
                              input bit rst);
        int d;
        bit succ, stall;
        m_wrap = 0; m_ill = 0; m_seq = 0;
        if (rst) begin
            m_mode = 0; m_good = 0; m_idx = 0; m_err8 = 0; m_err2 = 0;
            return;
        end
        if (v) begin
            d = tbl[c];
            if (d < 0) begin
                m_ill = 1;
                m_mode = 0;
            end else begin
                succ  = (d == (m_idx + 1) % N);
                stall = (d == m_idx);
                if (m_mode == 0) begin
                    m_mode = 1; m_good = 0;
                end else if (succ) begin
                    if (m_mode == 1) begin
                        m_good++;
                        if (m_good == LC) m_mode = 2;
                    end else if (m_idx == N - 1) begin
                        m_wrap = 1;
                    end
                end else if (!stall) begin
                    m_seq = 1; m_mode = 1; m_good = 0;
                end
                m_idx = d;
            end
        end
        if (clr) begin
            m_err8 = 0; m_err2 = 0;
        end else if (m_ill || m_seq) begin
            if (m_err8 < 255) m_err8++;
            if (m_err2 < 3) m_err2++;
        end
    endtask

    task automatic compare();
        int oh;
        oh = (m_mode == 2) ? (1 << m_idx) : 0;
        chk("locked", int'(locked), int'(m_mode == 2));
        chk("phase_idx", int'(phase_idx), m_idx);
        chk("onehot", int'(phase_onehot), oh);
        chk("wrap", int'(wrap_pulse), m_wrap);
        chk("illegal", int'(illegal_code), m_ill);
        chk("seq_err", int'(seq_err), m_seq);
        chk("err8", int'(err_count), m_err8);
        chk("err2", int'(s_err_count), m_err2);
        chk("s_locked", int'(s_locked), int'(m_mode == 2));
        chk("s_idx", int'(s_phase_idx), m_idx);
    endtask

    task automatic step(input int c, input bit v, input bit clr, input bit rst);
        @(negedge clk);
        code_in = W'(c); code_valid = v; clear_err = clr; reset = rst;
        @(posedge clk);
        model_step(c, v, clr, rst);
        #1;
        compare();
    endtask

    task automatic feed(input int i);
        step(jc(i), 1'b1, 1'b0, 1'b0);
    endtask

    int p, r, c, tries;

    initial begin
        for (int i = 0; i < (1 << W); i++) tbl[i] = -1;
        for (int i = 0; i < N; i++) tbl[jc(i)] = i;

        step(0, 1'b0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(err_count), 0);
        step(0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) feed(i);
        chk("lock_up", int'(locked), 1);
        chk("lock_idx", int'(phase_idx), 3);
        chk("lock_oh", int'(phase_onehot), 8);

        for (int i = 4; i < N; i++) feed(i);
        chk("pre_wrap", int'(wrap_pulse), 0);
        feed(0);
        chk("wrap_hi", int'(wrap_pulse), 1);
        chk("wrap_idx", int'(phase_idx), 0);
        feed(1);
        chk("wrap_lo", int'(wrap_pulse), 0);

        for (int i = 2; i <= 6; i++) feed(i);
        feed(6); feed(6);
        step(0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0);
        chk("stall_lock", int'(locked), 1);
        chk("stall_idx", int'(phase_idx), 6);
        chk("stall_err", int'(err_count), 0);

        feed(7); feed(0); feed(1); feed(2);
        feed(4);
        chk("skip_seq", int'(seq_err), 1);
        chk("skip_unlock", int'(locked), 0);
        chk("skip_idx", int'(phase_idx), 4);
        chk("skip_err", int'(err_count), 1);
        feed(5); feed(6);
        chk("relock_no", int'(locked), 0);
        feed(7);
        chk("relock", int'(locked), 1);

        step(4'b1010, 1'b1, 1'b0, 1'b0);
        chk("ill_pulse", int'(illegal_code), 1);
        chk("ill_idx", int'(phase_idx), 7);
        chk("ill_oh", int'(phase_onehot), 0);
        chk("ill_err", int'(err_count), 2);

        step(0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0100, 1'b1, 1'b0, 1'b0);
        chk("sat_err2", int'(s_err_count), 3);
        step(4'b1011, 1'b1, 1'b1, 1'b0);
        chk("clr_err2", int'(s_err_count), 0);
        chk("clr_err8", int'(err_count), 0);
        feed(2); feed(3);
        step(jc(4), 1'b1, 1'b0, 1'b1);
        chk("rst_mid_idx", int'(phase_idx), 0);
        chk("rst_mid_oh", int'(phase_onehot), 0);

        p = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = $urandom_range(0, 199);
            if (r < 120) begin
                p = (p + 1) % N; feed(p);
            end else if (r < 140) begin
                feed(p);
            end else if (r < 155) begin
                step(jc((p + 1) % N), 1'b0, 1'b0, 1'b0);
            end else if (r < 168) begin
                p = $urandom_range(0, N - 1); feed(p);
            end else if (r < 180) begin
                tries = 0;
                do begin
                    c = $urandom_range(0, (1 << W) - 1);
                    tries++;
                end while (tbl[c] >= 0 && tries < 64);
                step(c, 1'b1, 1'b0, 1'b0);
            end else if (r < 197) begin
                p = (p + 1) % N;
                step(jc(p), 1'b1, 1'b1, 1'b0);
            end else begin
                step(jc(p), 1'b1, 1'b0, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
